// File: rtl/user_obi_copy_mgr_pkg.sv
// Shared types and constants for the OBI word-copy manager.
// Holds the FSM state encoding, the word size and the manager-port ID width.
package user_obi_copy_mgr_pkg;

    localparam int unsigned WORD_BYTES = 4;

    // Matches the ID width of the SoC manager OBI configuration.
    localparam int unsigned MGR_OBI_ID_WIDTH = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } copy_state_e;

endpackage

// File: rtl/user_obi_copy_mgr_if.sv
// OBI manager-side bundle (request channel and response channel).
// The manager drives the request fields and the subordinate drives gnt and the response.
interface user_obi_copy_mgr_if
    import user_obi_copy_mgr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = MGR_OBI_ID_WIDTH
);
    logic                  req;
    logic                  we;
    logic [3:0]            be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ID_WIDTH-1:0]   aid;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic                  err;

    modport master (
        output req, we, be, addr, wdata, aid,
        input  gnt, rvalid, rdata, rid, err
    );

    modport slave (
        input  req, we, be, addr, wdata, aid,
        output gnt, rvalid, rdata, rid, err
    );

endinterface

// File: rtl/user_obi_copy_mgr.sv
// Word-by-word memory copy over OBI: one read then one write per word, one transaction outstanding.
// Zero-wait subordinate gives done_o 4N+1 cycles after start; a stalled gnt_i/rvalid_i simply holds the FSM.
module user_obi_copy_mgr
    import user_obi_copy_mgr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = MGR_OBI_ID_WIDTH,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MGR_ID     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,

    output logic                  req_o,
    output logic                  we_o,
    output logic [3:0]            be_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [ID_WIDTH-1:0]   aid_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [ID_WIDTH-1:0]   rid_i,
    input  logic                  err_i
);

    copy_state_e           r_state;
    copy_state_e           w_next;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_err;

    logic w_start;
    logic w_misalign;
    logic w_rsp;
    logic w_rsp_bad;

    assign w_start    = start_i && (r_state == ST_IDLE);
    assign w_misalign = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
    assign w_rsp      = rvalid_i && ((r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT));
    // A response is bad if flagged by the subordinate or addressed to another manager.
    assign w_rsp_bad  = err_i || (rid_i != ID_WIDTH'(MGR_ID));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_misalign || (len_i == '0)) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ:  if (gnt_i) w_next = ST_RD_WAIT;
            ST_RD_WAIT: if (rvalid_i) w_next = w_rsp_bad ? ST_DONE : ST_WR_REQ;
            ST_WR_REQ:  if (gnt_i) w_next = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (rvalid_i) begin
                    if (w_rsp_bad || (r_len == LEN_WIDTH'(1))) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_RD_REQ;
                    end
                end
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src <= '0;
            r_dst <= '0;
            r_len <= '0;
            r_buf <= '0;
            r_err <= 1'b0;
        end else if (w_start) begin
            r_src <= src_addr_i;
            r_dst <= dst_addr_i;
            r_len <= len_i;
            r_err <= w_misalign;
        end else if (w_rsp && w_rsp_bad) begin
            r_err <= 1'b1;
        end else if (w_rsp && (r_state == ST_RD_WAIT)) begin
            r_buf <= rdata_i;
        end else if (w_rsp) begin
            // Write acknowledged: advance both pointers, wrapping at the top of the address space.
            r_len <= r_len - LEN_WIDTH'(1);
            r_src <= r_src + ADDR_WIDTH'(WORD_BYTES);
            r_dst <= r_dst + ADDR_WIDTH'(WORD_BYTES);
        end
    end

    always_comb begin
        req_o   = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
        we_o    = (r_state == ST_WR_REQ);
        be_o    = 4'hF;
        aid_o   = ID_WIDTH'(MGR_ID);
        addr_o  = '0;
        wdata_o = '0;
        if (r_state == ST_RD_REQ) begin
            addr_o = r_src;
        end else if (r_state == ST_WR_REQ) begin
            addr_o  = r_dst;
            wdata_o = r_buf;
        end
        busy_o  = (r_state != ST_IDLE);
        done_o  = (r_state == ST_DONE);
        err_o   = r_err;
    end

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Bench for user_obi_copy_mgr: reactive OBI subordinate with configurable grant delay and
// error injection, and a transaction-list reference model of the copy.
module tb_user_obi_copy_mgr;
    import user_obi_copy_mgr_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = MGR_OBI_ID_WIDTH;
    localparam int unsigned LW  = 16;
    localparam int unsigned MID = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_a;
    logic [AW-1:0] dst_a;
    logic [LW-1:0] len;
    logic          busy, done, err;

    always #5 clk = ~clk;

    user_obi_copy_mgr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) obi ();

    user_obi_copy_mgr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .MGR_ID(MID)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .start_i(start), .src_addr_i(src_a), .dst_addr_i(dst_a), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err),
        .req_o(obi.req), .we_o(obi.we), .be_o(obi.be), .addr_o(obi.addr),
        .wdata_o(obi.wdata), .aid_o(obi.aid),
        .gnt_i(obi.gnt), .rvalid_i(obi.rvalid), .rdata_i(obi.rdata),
        .rid_i(obi.rid), .err_i(obi.err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Subordinate configuration and observation logs
    int          gnt_delay = 0;
    int          err_on_rd = 0;
    int          err_mode  = 0;
    int          wait_cnt  = 0;
    int          rd_cnt    = 0;
    int          unstable  = 0;
    int          bad_const = 0;
    bit          pend      = 0;
    bit          pend_err;
    bit          pend_rid_bad;
    logic [31:0] pend_data;
    bit          held      = 0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic [31:0] seed;
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    initial begin : subordinate
        obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.rdata = '0; obi.rid = '0; obi.err = 1'b0;
        forever begin
            @(negedge clk);
            obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.err = 1'b0; obi.rid = IW'(MID);
            if (!rst_n) begin
                pend = 0; wait_cnt = 0; held = 0;
            end else begin
                if (pend) begin
                    obi.rvalid = 1'b1; obi.rdata = pend_data; obi.err = pend_err;
                    obi.rid = pend_rid_bad ? ~IW'(MID) : IW'(MID);
                    pend = 0;
                end
                if (obi.req) begin
                    if (obi.be !== 4'hF || obi.aid !== IW'(MID)) bad_const++;
                    if (held && (obi.addr !== h_addr || obi.we !== h_we || obi.wdata !== h_wdata))
                        unstable++;
                    if (wait_cnt == gnt_delay) begin
                        obi.gnt = 1'b1; wait_cnt = 0; held = 0; pend = 1;
                        pend_err = 0; pend_rid_bad = 0;
                        if (obi.we) begin
                            wr_addr_log.push_back(obi.addr);
                            wr_data_log.push_back(obi.wdata);
                            pend_data = 32'h0;
                        end else begin
                            rd_cnt++;
                            rd_log.push_back(obi.addr);
                            pend_data = mem_val(obi.addr);
                            if (rd_cnt == err_on_rd) begin
                                pend_err     = (err_mode == 0);
                                pend_rid_bad = (err_mode == 1);
                            end
                        end
                    end else begin
                        wait_cnt++; held = 1;
                        h_addr = obi.addr; h_we = obi.we; h_wdata = obi.wdata;
                    end
                end else if (held) begin
                    unstable++;
                    held = 0;
                end
            end
        end
    end

    // Runs one copy from a start pulse in cycle 0; reports the first done cycle and pulse count.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int delay, input int errk, input int emode, input bit poke,
                            output int done_cyc, output int done_cnt,
                            output logic err_at_done, output logic err_end, output logic busy_end);
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        rd_cnt = 0; unstable = 0; bad_const = 0;
        gnt_delay = delay; err_on_rd = errk; err_mode = emode;
        done_cyc = -1; done_cnt = 0; err_at_done = 1'bx;
        @(negedge clk);
        start = 1'b1; src_a = s; dst_a = d; len = l;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && c == 3) begin
                start = 1'b1; src_a = 32'h3000; dst_a = 32'h4000; len = 16'd7;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; err_at_done = err; end
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
        err_end = err; busy_end = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; src_a = '0; dst_a = '0; len = '0;
        seed = $urandom;
        repeat (3) @(negedge clk);
        n_checks++; if (obi.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", obi.req); end
        n_checks++; if (obi.we !== 1'b0 || obi.addr !== 32'h0 || obi.wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: we=%b addr=%h wdata=%h want 0/0/0", obi.we, obi.addr, obi.wdata); end
        n_checks++; if ({busy, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: busy/done/err=%b want 000", {busy, done, err}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Checks one normal or error-terminated copy against the word-list model.
    task automatic test_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] l, input int delay, input int errk, input int emode);
        int dc, dn, nr, nw, exp_dc;
        logic ead, ee, be;
        logic [31:0] ea;
        run_copy(s, d, l, delay, errk, emode, 1'b0, dc, dn, ead, ee, be);
        nr = (errk != 0) ? errk : int'(l);
        nw = (errk != 0) ? errk - 1 : int'(l);
        exp_dc = (errk != 0) ? (errk - 1) * (4 + 2 * delay) + delay + 3 : 1 + int'(l) * (4 + 2 * delay);
        n_checks++; if (rd_log.size() != nr) begin n_fail++; $display("FAIL %s_nreads: got %0d want %0d", name, rd_log.size(), nr); end
        n_checks++; if (wr_addr_log.size() != nw) begin n_fail++; $display("FAIL %s_nwrites: got %0d want %0d", name, wr_addr_log.size(), nw); end
        for (int i = 0; i < nr && i < rd_log.size(); i++) begin
            ea = s + 32'(4 * i);
            n_checks++; if (rd_log[i] !== ea) begin n_fail++; $display("FAIL %s_rd_addr[%0d]: got %h want %h", name, i, rd_log[i], ea); end
        end
        for (int i = 0; i < nw && i < wr_addr_log.size(); i++) begin
            ea = d + 32'(4 * i);
            n_checks++; if (wr_addr_log[i] !== ea) begin n_fail++; $display("FAIL %s_wr_addr[%0d]: got %h want %h", name, i, wr_addr_log[i], ea); end
            ea = mem_val(s + 32'(4 * i));
            n_checks++; if (wr_data_log[i] !== ea) begin n_fail++; $display("FAIL %s_wr_data[%0d]: got %h want %h", name, i, wr_data_log[i], ea); end
        end
        n_checks++; if (dc != exp_dc) begin n_fail++; $display("FAIL %s_done_cycle: got %0d want %0d", name, dc, exp_dc); end
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d want 1", name, dn); end
        n_checks++; if (ead !== (errk != 0) || ee !== (errk != 0)) begin
            n_fail++; $display("FAIL %s_err: at done %b, after %b, want %b", name, ead, ee, errk != 0); end
        n_checks++; if (be !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after: got %b want 0", name, be); end
        n_checks++; if (unstable != 0 || bad_const != 0) begin
            n_fail++; $display("FAIL %s_req_hold: unstable=%0d bad_be_aid=%0d want 0/0", name, unstable, bad_const); end
    endtask

    task automatic test_basic();
        test_copy("basic", 32'h1000, 32'h2000, 16'd3, 0, 0, 0);
    endtask

    task automatic test_gnt_delay();
        test_copy("gnt_delay", 32'h0800, 32'h9000, 16'd3, 3, 0, 0);
    endtask

    task automatic test_wrap();
        test_copy("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            seed = $urandom;
            test_copy("random", {$urandom, 2'b00} & 32'h000F_FFFC, {$urandom, 2'b00} & 32'h00F0_FFFC,
                      16'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 0, 0);
        end
    endtask

    task automatic test_rsp_err();
        test_copy("rid_err", 32'h5000, 32'h6000, 16'd3, 0, 3, 1);
    endtask

    task automatic test_len0_misalign();
        int dc, dn;
        logic ead, ee, be;
        logic [31:0] s_tab [3] = '{32'h1000, 32'h1002, 32'h1000};
        logic [31:0] d_tab [3] = '{32'h2000, 32'h2000, 32'h2001};
        logic [15:0] l_tab [3] = '{16'd0, 16'd2, 16'd2};
        for (int k = 0; k < 3; k++) begin
            run_copy(s_tab[k], d_tab[k], l_tab[k], 0, 0, 0, 1'b0, dc, dn, ead, ee, be);
            n_checks++; if (rd_log.size() + wr_addr_log.size() != 0) begin
                n_fail++; $display("FAIL no_traffic[%0d]: got %0d requests want 0", k, rd_log.size() + wr_addr_log.size()); end
            n_checks++; if (dc != 1 || dn != 1) begin
                n_fail++; $display("FAIL short_done[%0d]: cycle %0d pulses %0d want 1/1", k, dc, dn); end
            n_checks++; if (ead !== (k != 0)) begin
                n_fail++; $display("FAIL short_err[%0d]: got %b want %b", k, ead, k != 0); end
        end
    endtask

    task automatic test_err_busy_start();
        int dc, dn;
        logic ead, ee, be;
        run_copy(32'h1000, 32'h2000, 16'd4, 0, 2, 0, 1'b1, dc, dn, ead, ee, be);
        n_checks++; if (wr_addr_log.size() != 1) begin n_fail++; $display("FAIL rd_err_writes: got %0d want 1", wr_addr_log.size()); end
        n_checks++; if (rd_log.size() != 2 || rd_log[0] !== 32'h1000 || rd_log[1] !== 32'h1004) begin
            n_fail++; $display("FAIL rd_err_reads: got %0d reads want 2 at 1000/1004", rd_log.size()); end
        n_checks++; if (ead !== 1'b1 || ee !== 1'b1) begin n_fail++; $display("FAIL rd_err_flag: got %b/%b want 1/1", ead, ee); end
        n_checks++; if (dc != 7 || dn != 1) begin n_fail++; $display("FAIL rd_err_done: cycle %0d pulses %0d want 7/1", dc, dn); end
        // A clean start afterwards must clear the sticky error.
        test_copy("err_clear", 32'h0100, 32'h0200, 16'd1, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        gnt_delay = 3; err_on_rd = 0;
        @(negedge clk);
        start = 1'b1; src_a = 32'h0400; dst_a = 32'h0480; len = 16'd2;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (obi.req === 1'b1 && obi.we === 1'b1) hit = 1;
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL mid_reach_wr_req: got 0 want 1"); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (obi.req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: req=%b busy=%b want 0/0", obi.req, busy); end
        n_checks++; if (obi.addr !== 32'h0 || obi.wdata !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_bus: addr=%h wdata=%h done=%b err=%b want 0", obi.addr, obi.wdata, done, err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_copy("after_reset", 32'h0700, 32'h0A00, 16'd1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_delay();
        test_len0_misalign();
        test_err_busy_start();
        test_rsp_err();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
